// File: rtl/fir_param.sv
// Parametrised, pipelined direct-form FIR filter.
// Stage 1 shifts the delay line and registers the tap products on each accepted
// sample. Stage 2 sums, rounds, scales and saturates the products into o_y.
module fir_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 5,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 0,
    localparam int unsigned ADDR_W = $clog2(TAPS),
    localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic                     i_coef_we,
    input  logic [ADDR_W-1:0]        i_coef_addr,
    input  logic signed [COEF_W-1:0] i_coef_data,
    output logic                     o_valid,
    output logic signed [OUT_W-1:0]  o_y,
    output logic                     o_sat,
    output logic [TAPS*DATA_W-1:0]   o_delay_flat
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    // Rounding constant 2^(SHIFT-1), or zero when no scaling is applied.
    localparam logic signed [ACC_W-1:0] RND = (ACC_W'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] dly_q  [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic                     v1_q;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [OUT_W-1:0]  y_d;
    logic                     sat_d;

    logic                     valid_q;
    logic signed [OUT_W-1:0]  y_q;
    logic                     sat_q;

    // Full-precision signed product; operands widened first so no bits are lost.
    function automatic logic signed [PROD_W-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                     input logic signed [DATA_W-1:0] x);
        logic signed [PROD_W-1:0] ce;
        logic signed [PROD_W-1:0] xe;
        ce = PROD_W'(c);
        xe = PROD_W'(x);
        return ce * xe;
    endfunction

    // Coefficient bank: out-of-range addresses match no tap and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) coef_q[k] <= '0;
        end else if (i_coef_we) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                if (i_coef_addr == ADDR_W'(k)) coef_q[k] <= i_coef_data;
            end
        end
    end

    // Delay line shift and stage-1 products, both only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                dly_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            v1_q <= 1'b0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                dly_q[0]  <= i_x;
                prod_q[0] <= mul(coef_q[0], i_x);
                for (int k = 1; k < int'(TAPS); k++) begin
                    dly_q[k]  <= dly_q[k-1];
                    // dly_q[k-1] is what d[k] becomes after this edge.
                    prod_q[k] <= mul(coef_q[k], dly_q[k-1]);
                end
            end
        end
    end

    // Sum the products, round-half-up scale, then clamp to the output range.
    always_comb begin
        acc = '0;
        for (int k = 0; k < int'(TAPS); k++) acc = acc + ACC_W'(prod_q[k]);
        scaled = (acc + RND) >>> SHIFT;
        sat_d  = 1'b0;
        y_d    = scaled[OUT_W-1:0];
        if (scaled > OUT_MAX) begin
            y_d   = OUT_MAX[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (scaled < OUT_MIN) begin
            y_d   = OUT_MIN[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    // Stage-2 output register; result and clamp flag hold while no new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= v1_q;
            if (v1_q) begin
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    // Flatten the delay line with d[0] in the least significant slot.
    always_comb begin
        o_delay_flat = '0;
        for (int k = 0; k < int'(TAPS); k++) o_delay_flat[DATA_W*k +: DATA_W] = dly_q[k];
    end

    assign o_valid = valid_q;
    assign o_y     = y_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param: a default instance plus a SHIFT=1 instance
// sharing the same stimulus, with table-driven vectors and short hand sequences.
module tb_fir_param;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic signed [7:0] i_x;
    logic              i_coef_we;
    logic [2:0]        i_coef_addr;
    logic signed [7:0] i_coef_data;

    logic              o_valid;
    logic signed [7:0] o_y;
    logic              o_sat;
    logic [39:0]       o_delay_flat;

    logic              r_valid;
    logic signed [7:0] r_y;
    logic              r_sat;
    logic [39:0]       r_delay_flat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              v;
        logic signed [7:0] x;
        logic              ev;
        logic signed [7:0] ey;
        logic              es;
    } vec_t;

    vec_t vq[$];

    fir_param u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_x          (i_x),
        .i_coef_we    (i_coef_we),
        .i_coef_addr  (i_coef_addr),
        .i_coef_data  (i_coef_data),
        .o_valid      (o_valid),
        .o_y          (o_y),
        .o_sat        (o_sat),
        .o_delay_flat (o_delay_flat)
    );

    fir_param #(.SHIFT(1)) u_rnd (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_x          (i_x),
        .i_coef_we    (i_coef_we),
        .i_coef_addr  (i_coef_addr),
        .i_coef_data  (i_coef_data),
        .o_valid      (r_valid),
        .o_y          (r_y),
        .o_sat        (r_sat),
        .o_delay_flat (r_delay_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_x       = '0;
        i_coef_we = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        i_coef_we   = 1'b1;
        i_coef_addr = 3'(addr);
        i_coef_data = 8'(data);
        step();
        i_coef_we = 1'b0;
    endtask

    task automatic load5(input int c0, input int c1, input int c2, input int c3, input int c4);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
        write_coef(4, c4);
    endtask

    task automatic add(input logic v, input int x, input logic ev, input int ey, input logic es);
        vec_t r;
        r.v  = v;
        r.x  = 8'(x);
        r.ev = ev;
        r.ey = 8'(ey);
        r.es = es;
        vq.push_back(r);
    endtask

    // Each row drives one cycle; its expectation is the output seen after that edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            i_valid = vq[i].v;
            i_x     = vq[i].x;
            step();
            check($sformatf("%s[%0d].valid", tag, i), o_valid, vq[i].ev);
            check($sformatf("%s[%0d].y", tag, i), o_y, vq[i].ey);
            check($sformatf("%s[%0d].sat", tag, i), o_sat, vq[i].es);
        end
        vq.delete();
        i_valid = 1'b0;
        i_x     = '0;
    endtask

    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_x         = '0;
        i_coef_we   = 1'b0;
        i_coef_addr = '0;
        i_coef_data = '0;
        step();
        step();
        rst = 1'b0;
        check("reset.valid", o_valid, 0);
        check("reset.y", o_y, 0);
        check("reset.sat", o_sat, 0);
        check("reset.delay", o_delay_flat, 0);

        // Moving sum
        do_reset();
        load5(1, 1, 1, 1, 1);
        add(1, 1, 0, 0, 0);
        add(1, -6, 1, 1, 0);
        add(1, 10, 1, -5, 0);
        add(1, 2, 1, 5, 0);
        add(1, -4, 1, 7, 0);
        add(0, 0, 1, 3, 0);
        add(0, 0, 0, 3, 0);
        run_vecs("msum");
        check("msum.delay", o_delay_flat, 40'h01_FA_0A_02_FC);

        // Impulse reads the coefficients back in tap order
        do_reset();
        load5(3, -2, 5, 0, 7);
        add(1, 1, 0, 0, 0);
        add(1, 0, 1, 3, 0);
        add(1, 0, 1, -2, 0);
        add(1, 0, 1, 5, 0);
        add(1, 0, 1, 0, 0);
        add(0, 0, 1, 7, 0);
        add(0, 0, 0, 7, 0);
        run_vecs("impulse");

        // Saturation both ways, then recovery
        do_reset();
        load5(100, 100, 100, 100, 100);
        add(1, 127, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add(1, 127, 1, 127, 1);
        add(1, -128, 1, 127, 1);
        add(1, -128, 1, 127, 1);
        add(1, -128, 1, 127, 1);
        add(1, -128, 1, -128, 1);
        add(1, -128, 1, -128, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 1, -128, 1);
        add(1, 1, 1, 0, 0);
        add(0, 0, 1, 100, 0);
        add(0, 0, 0, 100, 0);
        run_vecs("sat");

        // Valid gaps; out-of-range write ignored; consecutive writes keep the last
        do_reset();
        load5(1, 1, 1, 1, 1);
        write_coef(7, 50);
        write_coef(1, 9);
        write_coef(1, 1);
        add(1, 2, 0, 0, 0);
        add(0, 99, 1, 2, 0);
        add(1, 5, 0, 2, 0);
        add(0, 0, 1, 7, 0);
        add(0, 0, 0, 7, 0);
        run_vecs("gap");

        // Coefficient write alongside a valid sample uses the old value
        i_valid     = 1'b1;
        i_x         = 8'sd1;
        i_coef_we   = 1'b1;
        i_coef_addr = 3'd0;
        i_coef_data = 8'sd2;
        step();
        i_coef_we = 1'b0;
        step();
        check("cwr.old.valid", o_valid, 1);
        check("cwr.old.y", o_y, 8);
        i_valid = 1'b0;
        step();
        check("cwr.new.valid", o_valid, 1);
        check("cwr.new.y", o_y, 10);

        // Rounding: SHIFT=1 instance against the unscaled one
        do_reset();
        load5(1, 0, 0, 0, 0);
        i_valid = 1'b1;
        i_x     = 8'sd3;
        step();
        i_x = -8'sd3;
        step();
        check("rnd.p3.valid", r_valid, 1);
        check("rnd.p3.y", r_y, 2);
        check("rnd.p3.sat", r_sat, 0);
        check("raw.p3.y", o_y, 3);
        i_x = 8'sd4;
        step();
        check("rnd.m3.y", r_y, -1);
        check("rnd.m3.sat", r_sat, 0);
        check("raw.m3.y", o_y, -3);
        i_valid = 1'b0;
        step();
        check("rnd.p4.y", r_y, 2);
        check("rnd.p4.sat", r_sat, 0);
        check("raw.p4.y", o_y, 4);

        // Reset with two samples in flight, colliding with valid and a coef write
        i_valid = 1'b1;
        i_x     = 8'sd3;
        step();
        i_x = 8'sd4;
        step();
        check("mrst.pre.valid", o_valid, 1);
        check("mrst.pre.y", o_y, 3);
        rst         = 1'b1;
        i_x         = 8'sd5;
        i_coef_we   = 1'b1;
        i_coef_addr = 3'd0;
        i_coef_data = 8'sd7;
        step();
        check("mrst.valid", o_valid, 0);
        check("mrst.y", o_y, 0);
        check("mrst.sat", o_sat, 0);
        check("mrst.delay", o_delay_flat, 0);
        rst       = 1'b0;
        i_valid   = 1'b0;
        i_coef_we = 1'b0;
        step();
        check("mrst.flush.valid", o_valid, 0);
        check("mrst.flush.y", o_y, 0);
        i_valid = 1'b1;
        i_x     = 8'sd1;
        step();
        check("mrst.imp.delay", o_delay_flat, 40'h00_00_00_00_01);
        i_valid = 1'b0;
        step();
        check("mrst.imp.valid", o_valid, 1);
        check("mrst.imp.y", o_y, 0);
        step();
        check("mrst.after.valid", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
